// File: rtl/gyro_poll_ctrl.sv
// gyro_poll_ctrl: periodic read-request generator and sample
// post-processor wrapped around the gyro SPI master.
//
// Ports:
//   sys_clk_i, rst_i     clock, synchronous active-high reset
//   en_i                 polling enable (low parks in IDLE)
//   cal_i                pulse: next received byte becomes offset
//   tx_ready_i/tx_dv_o   SPI master ready / one-cycle read request
//   rx_dv_i/rx_byte_i    SPI master received-byte strobe and data
//   sample_o/_vld_o      signed corrected sample and its strobe
//   offset_o             current calibration offset
//   overrun_o/timeout_o  sticky error flags
//
// Build option: define GYRO_POLL_AVG_EN to average 2^AVG_LOG2
// corrected samples per output strobe.
module gyro_poll_ctrl #(
  parameter int POLL_DIV = 50000,
  parameter int AVG_LOG2 = 2,
  parameter int TIMEOUT  = 1024
) (
  input  logic       sys_clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic       cal_i,
  input  logic       tx_ready_i,
  output logic       tx_dv_o,
  input  logic       rx_dv_i,
  input  logic [7:0] rx_byte_i,
  output logic [7:0] sample_o,
  output logic       sample_vld_o,
  output logic [7:0] offset_o,
  output logic       overrun_o,
  output logic       timeout_o
);

  localparam int DW = $clog2(POLL_DIV);
  localparam int TW = $clog2(TIMEOUT + 1);

  if (POLL_DIV < 4) begin : g_bad_div
    $error("POLL_DIV must be at least 4");
  end
  if (AVG_LOG2 < 0 || AVG_LOG2 > 4) begin : g_bad_avg
    $error("AVG_LOG2 must be in 0..4");
  end

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    REQ,
    WAIT_RX,
    PROC
  } state_t;

  state_t state;
  state_t next;

  logic [DW-1:0] div;
  logic [TW-1:0] tcnt;
  logic          tick;
  logic          pending;
  logic          expire;
  logic          accept;
  logic          proc;
  logic          cal_req;
  logic          rx_cal;
  logic [7:0]    rx_buf;
  logic [7:0]    offset;
  logic [7:0]    sample;
  logic          vld;
  logic          tx_dv;
  logic          overrun;
  logic          timeout;

  logic signed [8:0] wide;
  logic signed [7:0] diff;

  assign tick   = en_i && (div == DW'(POLL_DIV - 1));
  assign expire = (tcnt == TW'(TIMEOUT - 1));
  assign accept = en_i && (state == WAIT_RX) && rx_dv_i;
  assign proc   = en_i && (state == PROC);

  always_comb begin
    next = state;
    if (!en_i) begin
      next = IDLE;
    end else begin
      unique case (state)
        IDLE:    next = WAIT;
        WAIT:    if (pending && tx_ready_i) next = REQ;
        REQ:     next = WAIT_RX;
        WAIT_RX: begin
          if (rx_dv_i)     next = PROC;
          else if (expire) next = WAIT;
        end
        PROC:    next = WAIT;
        default: next = IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      div     <= '0;
      pending <= 1'b0;
      tx_dv   <= 1'b0;
      tcnt    <= '0;
      overrun <= 1'b0;
      timeout <= 1'b0;
      cal_req <= 1'b0;
      rx_cal  <= 1'b0;
      rx_buf  <= '0;
    end else begin
      state <= next;
      tx_dv <= (next == REQ);

      if (!en_i || tick) div <= '0;
      else               div <= div + 1'b1;

      // A tick landing on the REQ cycle re-arms the request
      // rather than counting as an overrun.
      if (!en_i)              pending <= 1'b0;
      else if (tick)          pending <= 1'b1;
      else if (state == REQ)  pending <= 1'b0;

      if (tick && pending && state != REQ) overrun <= 1'b1;

      if (state == REQ)          tcnt <= '0;
      else if (state == WAIT_RX) tcnt <= tcnt + 1'b1;

      if (en_i && state == WAIT_RX && !rx_dv_i && expire)
        timeout <= 1'b1;

      // A cal pulse coinciding with the accepted byte claims it.
      if (!en_i)       cal_req <= 1'b0;
      else if (accept) cal_req <= 1'b0;
      else if (cal_i)  cal_req <= 1'b1;

      if (accept) begin
        rx_buf <= rx_byte_i;
        rx_cal <= cal_req | cal_i;
      end
    end
  end

  assign wide = $signed({rx_buf[7], rx_buf})
              - $signed({offset[7], offset});

  always_comb begin
    diff = wide[7:0];
    if (wide[8] != wide[7])
      diff = wide[8] ? 8'sh80 : 8'sh7F;
  end

  always_ff @(posedge sys_clk_i) begin
    if (rst_i)                offset <= '0;
    else if (proc && rx_cal)  offset <= rx_buf;
  end

`ifdef GYRO_POLL_AVG_EN
  localparam int AW = 8 + AVG_LOG2;
  localparam int CW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] sum;
  logic [CW-1:0]        cnt;
  logic                 last;

  // Window of 2^AVG_LOG2 8-bit samples fits in AW bits.
  assign sum  = acc + AW'(diff);
  assign last = (cnt == CW'((1 << AVG_LOG2) - 1));

  always_ff @(posedge sys_clk_i) begin
    if (rst_i) begin
      acc    <= '0;
      cnt    <= '0;
      sample <= '0;
      vld    <= 1'b0;
    end else begin
      vld <= 1'b0;
      if (!en_i) begin
        acc <= '0;
        cnt <= '0;
      end else if (proc && !rx_cal) begin
        if (last) begin
          sample <= 8'(sum >>> AVG_LOG2);
          vld    <= 1'b1;
          acc    <= '0;
          cnt    <= '0;
        end else begin
          acc <= sum;
          cnt <= cnt + 1'b1;
        end
      end
    end
  end
`else
  always_ff @(posedge sys_clk_i) begin
    if (rst_i) begin
      sample <= '0;
      vld    <= 1'b0;
    end else begin
      vld <= 1'b0;
      if (proc && !rx_cal) begin
        sample <= diff;
        vld    <= 1'b1;
      end
    end
  end
`endif

  assign tx_dv_o      = tx_dv;
  assign sample_o     = sample;
  assign sample_vld_o = vld;
  assign offset_o     = offset;
  assign overrun_o    = overrun;
  assign timeout_o    = timeout;

endmodule

// File: tb/tb_gyro_poll_ctrl.sv
// tb_gyro_poll_ctrl: directed self-checking bench for gyro_poll_ctrl
// with POLL_DIV=8, AVG_LOG2=2, TIMEOUT=16.
module tb_gyro_poll_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       cal;
  logic       rdy;
  logic       tx_dv;
  logic       rx_dv;
  logic [7:0] rx_byte;
  logic [7:0] sample;
  logic       vld;
  logic [7:0] offset;
  logic       overrun;
  logic       timeout;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  gyro_poll_ctrl #(
    .POLL_DIV(8),
    .AVG_LOG2(2),
    .TIMEOUT (16)
  ) dut (
    .sys_clk_i   (clk),
    .rst_i       (rst),
    .en_i        (en),
    .cal_i       (cal),
    .tx_ready_i  (rdy),
    .tx_dv_o     (tx_dv),
    .rx_dv_i     (rx_dv),
    .rx_byte_i   (rx_byte),
    .sample_o    (sample),
    .sample_vld_o(vld),
    .offset_o    (offset),
    .overrun_o   (overrun),
    .timeout_o   (timeout)
  );

  typedef struct {
    logic [1:0] cal;
    logic [7:0] din;
    logic       vld_raw;
    logic [7:0] s_raw;
    logic       vld_avg;
    logic [7:0] s_avg;
    logic [7:0] off;
  } vec_t;

  vec_t vt[20];

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  task automatic wait_tx(input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      seen = tx_dv;
    end
    chk(name, 32'(seen), 32'd1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " tx_dv"},   32'(tx_dv),   0);
    chk({tag, " sample"},  32'(sample),  0);
    chk({tag, " vld"},     32'(vld),     0);
    chk({tag, " offset"},  32'(offset),  0);
    chk({tag, " overrun"}, 32'(overrun), 0);
    chk({tag, " timeout"}, 32'(timeout), 0);
  endtask

  initial begin
    logic       prev;
    logic       ev;
    logic [7:0] es;
    int         ntx;
    int         txc;

    // cal: 0 none, 1 with the byte, 2 pulsed on the request cycle
    vt[0]  = '{2'd1, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00};
    vt[1]  = '{2'd0, 8'h0A, 1'b1, 8'h0A, 1'b0, 8'h00, 8'h00};
    vt[2]  = '{2'd0, 8'h0B, 1'b1, 8'h0B, 1'b0, 8'h00, 8'h00};
    vt[3]  = '{2'd0, 8'h0C, 1'b1, 8'h0C, 1'b0, 8'h00, 8'h00};
    vt[4]  = '{2'd0, 8'h0E, 1'b1, 8'h0E, 1'b1, 8'h0B, 8'h00};
    vt[5]  = '{2'd2, 8'h05, 1'b0, 8'h00, 1'b0, 8'h00, 8'h05};
    vt[6]  = '{2'd0, 8'h03, 1'b1, 8'hFE, 1'b0, 8'h00, 8'h05};
    vt[7]  = '{2'd0, 8'h03, 1'b1, 8'hFE, 1'b0, 8'h00, 8'h05};
    vt[8]  = '{2'd0, 8'h00, 1'b1, 8'hFB, 1'b0, 8'h00, 8'h05};
    vt[9]  = '{2'd0, 8'h04, 1'b1, 8'hFF, 1'b1, 8'hFD, 8'h05};
    vt[10] = '{2'd1, 8'h7F, 1'b0, 8'h00, 1'b0, 8'h00, 8'h7F};
    vt[11] = '{2'd0, 8'h80, 1'b1, 8'h80, 1'b0, 8'h00, 8'h7F};
    vt[12] = '{2'd0, 8'h80, 1'b1, 8'h80, 1'b0, 8'h00, 8'h7F};
    vt[13] = '{2'd0, 8'h80, 1'b1, 8'h80, 1'b0, 8'h00, 8'h7F};
    vt[14] = '{2'd0, 8'h80, 1'b1, 8'h80, 1'b1, 8'h80, 8'h7F};
    vt[15] = '{2'd2, 8'h80, 1'b0, 8'h00, 1'b0, 8'h00, 8'h80};
    vt[16] = '{2'd0, 8'h7F, 1'b1, 8'h7F, 1'b0, 8'h00, 8'h80};
    vt[17] = '{2'd0, 8'h7F, 1'b1, 8'h7F, 1'b0, 8'h00, 8'h80};
    vt[18] = '{2'd0, 8'h7F, 1'b1, 8'h7F, 1'b0, 8'h00, 8'h80};
    vt[19] = '{2'd0, 8'h7F, 1'b1, 8'h7F, 1'b1, 8'h7F, 8'h80};

    rst = 1'b1; en = 1'b0; cal = 1'b0; rdy = 1'b1;
    rx_dv = 1'b0; rx_byte = 8'h00;
    step(); step();
    chk_zero("reset");
    rst = 1'b0;
    step();

    // Periodic poll: en rises in cycle 0, requests at 9, 17, 25.
    en = 1'b1;
    cyc = 0;
    prev = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      step();
      rx_dv = prev;
      rx_byte = 8'h00;
      chk($sformatf("poll tx_dv c%0d", c), 32'(tx_dv),
          32'((c == 9) || (c == 17) || (c == 25)));
      prev = tx_dv;
    end
    rx_dv = 1'b0;

    // Dropping en clears divider/accumulator before the table.
    en = 1'b0;
    step(); step(); step();
    en = 1'b1;

    for (int i = 0; i < 20; i++) begin
`ifdef GYRO_POLL_AVG_EN
      ev = vt[i].vld_avg;
      es = vt[i].s_avg;
`else
      ev = vt[i].vld_raw;
      es = vt[i].s_raw;
`endif
      wait_tx($sformatf("vec%0d request", i));
      if (vt[i].cal == 2'd2) cal = 1'b1;
      step();
      cal = (vt[i].cal == 2'd1);
      rx_dv = 1'b1;
      rx_byte = vt[i].din;
      step();
      cal = 1'b0;
      rx_dv = 1'b0;
      chk($sformatf("vec%0d early vld", i), 32'(vld), 0);
      step();
      chk($sformatf("vec%0d vld", i), 32'(vld), 32'(ev));
      if (ev)
        chk($sformatf("vec%0d sample", i), 32'(sample), 32'(es));
      chk($sformatf("vec%0d offset", i), 32'(offset),
          32'(vt[i].off));
    end

    // rx strobe while waiting for the next tick is ignored.
    rx_dv = 1'b1;
    rx_byte = 8'h11;
    step();
    rx_dv = 1'b0;
    step();
    chk("stray rx vld a", 32'(vld), 0);
    step();
    chk("stray rx vld b", 32'(vld), 0);

    // Ready held low: overrun, then exactly one request.
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    en = 1'b0;
    step();
    en = 1'b1;
    rdy = 1'b0;
    cyc = 0;
    ntx = 0;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (tx_dv) ntx++;
    end
    chk("no tx while not ready", 32'(ntx), 0);
    chk("overrun set", 32'(overrun), 1);
    chk("no timeout yet", 32'(timeout), 0);
    rdy = 1'b1;
    txc = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (tx_dv) begin
        ntx++;
        txc = cyc;
      end
    end
    chk("one tx after ready", 32'(ntx), 1);
    chk("tx after ready cycle", 32'(txc), 21);

    // No response: timeout 17 cycles after the request.
    while (cyc < txc + 16 && cyc < 200) step();
    chk("timeout at tx+16", 32'(timeout), 0);
    step();
    chk("timeout at tx+17", 32'(timeout), 1);
    wait_tx("request after timeout");
    step(); step(); step();
    rst = 1'b1;
    step();
    chk_zero("reset in wait_rx");
    rst = 1'b0;
    en = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
